// File: rtl/colisao_pkg.sv
// colisao_pkg: raster geometry, FSM state type and the squared-distance / rectangle helpers
// shared by the collision detector and its circle sub-module.
package colisao_pkg;

  localparam int H_ATIVO = 640;
  localparam int V_ATIVO = 480;
  localparam int COORD_W = 10;
  localparam int DIST_W  = 22;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ACUMULA = 2'd1,
    PUBLICA = 2'd2
  } estado_t;

  // |d| never exceeds 1023, so the magnitude fits COORD_W+1 bits and the square fits DIST_W.
  function automatic logic [DIST_W-1:0] quadrado(input logic signed [COORD_W:0] d);
    logic [COORD_W:0] mag;
    logic [DIST_W-1:0] m;
    mag = d[COORD_W] ? $unsigned(-d) : $unsigned(d);
    m   = DIST_W'(mag);
    return m * m;
  endfunction

  function automatic logic dentro_ret(
    input logic [COORD_W-1:0] px,
    input logic [COORD_W-1:0] py,
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [COORD_W-1:0] larg,
    input logic [COORD_W-1:0] alt
  );
    logic [COORD_W:0] x_fim;
    logic [COORD_W:0] y_fim;
    x_fim = {1'b0, x} + {1'b0, larg};
    y_fim = {1'b0, y} + {1'b0, alt};
    return (px >= x) && ({1'b0, px} < x_fim) && (py >= y) && ({1'b0, py} < y_fim);
  endfunction

endpackage

// File: rtl/colisao_raster_if.sv
// colisao_raster_if: one raster pixel (strobe, visible flag, coordinate) as seen by the pixel tests.
interface colisao_raster_if;
  import colisao_pkg::*;

  logic               pix_en;
  logic               ativo;
  logic [COORD_W-1:0] vga_x;
  logic [COORD_W-1:0] vga_y;

  modport master (output pix_en, ativo, vga_x, vga_y);
  modport slave  (input  pix_en, ativo, vga_x, vga_y);
endinterface

// File: rtl/circulo_contem.sv
// circulo_contem: two-stage registered "pixel inside circle" test; stage 1 squares, stage 2 compares.
module circulo_contem
  import colisao_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  colisao_raster_if.slave    pix,
  input  logic [COORD_W-1:0] cx_i,
  input  logic [COORD_W-1:0] cy_i,
  input  logic [COORD_W-1:0] raio_i,
  output logic               dentro_o
);

  logic signed [COORD_W:0] dx;
  logic signed [COORD_W:0] dy;
  logic [DIST_W-1:0]       dx2_q;
  logic [DIST_W-1:0]       dy2_q;
  logic [DIST_W-1:0]       r2_q;
  logic                    dentro_q;

  assign dx = $signed({1'b0, pix.vga_x}) - $signed({1'b0, cx_i});
  assign dy = $signed({1'b0, pix.vga_y}) - $signed({1'b0, cy_i});

  // The sum of two squares peaks near 2.1M, so DIST_W bits hold it without truncation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dx2_q    <= '0;
      dy2_q    <= '0;
      r2_q     <= '0;
      dentro_q <= 1'b0;
    end else begin
      if (pix.pix_en && pix.ativo) begin
        dx2_q <= quadrado(dx);
        dy2_q <= quadrado(dy);
        r2_q  <= quadrado($signed({1'b0, raio_i}));
      end
      dentro_q <= (dx2_q + dy2_q) <= r2_q;
    end
  end

  assign dentro_o = dentro_q;

endmodule

// File: rtl/colisao_raster.sv
// colisao_raster: counts per-frame pixel overlaps (ally ball/enemy, enemy ball/ship) and publishes hits.
// Define COLISAO_DEBUG_EN to latch the overlap counts onto dbg_cont_* whenever a result is published.
module colisao_raster
  import colisao_pkg::*;
#(
  parameter int LIMIAR = 4,
  parameter int CONT_W = 12
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               pix_en,
  input  logic [COORD_W-1:0] VGA_X,
  input  logic [COORD_W-1:0] VGA_Y,
  input  logic               ativo,
  input  logic               pausa,
  input  logic [COORD_W-1:0] x_bola_aliada,
  input  logic [COORD_W-1:0] y_bola_aliada,
  input  logic [COORD_W-1:0] raio_bola_aliada,
  input  logic [COORD_W-1:0] x_bola_inimiga,
  input  logic [COORD_W-1:0] y_bola_inimiga,
  input  logic [COORD_W-1:0] raio_bola_inimiga,
  input  logic [COORD_W-1:0] x_nave,
  input  logic [COORD_W-1:0] y_nave,
  input  logic [COORD_W-1:0] largura_nave,
  input  logic [COORD_W-1:0] altura_nave,
  input  logic [COORD_W-1:0] x_inimigo,
  input  logic [COORD_W-1:0] y_inimigo,
  input  logic [COORD_W-1:0] largura_inimigo,
  input  logic [COORD_W-1:0] altura_inimigo,
  input  logic               inimigo_vivo,
  output logic               hit_inimigo,
  output logic               hit_nave,
  output logic               valido,
  input  logic               ack,
  output logic               overrun,
  output logic [CONT_W-1:0]  dbg_cont_inimigo,
  output logic [CONT_W-1:0]  dbg_cont_nave,
  output estado_t            dbg_estado
);

  localparam int unsigned LIMIAR_U = LIMIAR;

  colisao_raster_if pix_if ();
  assign pix_if.pix_en = pix_en;
  assign pix_if.ativo  = ativo;
  assign pix_if.vga_x  = VGA_X;
  assign pix_if.vga_y  = VGA_Y;

  logic px_ok;
  logic inicio;
  logic ultimo;
  assign px_ok  = pix_en & ativo;
  assign inicio = px_ok && (VGA_X == '0) && (VGA_Y == '0);
  assign ultimo = px_ok && (VGA_X == COORD_W'(H_ATIVO - 1)) && (VGA_Y == COORD_W'(V_ATIVO - 1));

  logic dentro_aliada;
  logic dentro_inimiga;

  circulo_contem u_bola_aliada (
    .clk_i    (CLOCK_50),
    .rst_i    (reset),
    .pix      (pix_if),
    .cx_i     (x_bola_aliada),
    .cy_i     (y_bola_aliada),
    .raio_i   (raio_bola_aliada),
    .dentro_o (dentro_aliada)
  );

  circulo_contem u_bola_inimiga (
    .clk_i    (CLOCK_50),
    .rst_i    (reset),
    .pix      (pix_if),
    .cx_i     (x_bola_inimiga),
    .cy_i     (y_bola_inimiga),
    .raio_i   (raio_bola_inimiga),
    .dentro_o (dentro_inimiga)
  );

  // Rectangle flags and pixel tags travel alongside the circle pipeline.
  logic v1_q, ult1_q, ret_ini1_q, ret_nave1_q;
  logic v2_q, ult2_q, ret_ini2_q, ret_nave2_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      v1_q        <= 1'b0;
      ult1_q      <= 1'b0;
      ret_ini1_q  <= 1'b0;
      ret_nave1_q <= 1'b0;
      v2_q        <= 1'b0;
      ult2_q      <= 1'b0;
      ret_ini2_q  <= 1'b0;
      ret_nave2_q <= 1'b0;
    end else begin
      v1_q        <= px_ok;
      ult1_q      <= ultimo;
      ret_ini1_q  <= inimigo_vivo &&
                     dentro_ret(VGA_X, VGA_Y, x_inimigo, y_inimigo, largura_inimigo, altura_inimigo);
      ret_nave1_q <= dentro_ret(VGA_X, VGA_Y, x_nave, y_nave, largura_nave, altura_nave);
      v2_q        <= v1_q;
      ult2_q      <= ult1_q;
      ret_ini2_q  <= ret_ini1_q;
      ret_nave2_q <= ret_nave1_q;
    end
  end

  logic conta_ini;
  logic conta_nave;
  assign conta_ini  = v2_q & ret_ini2_q & dentro_aliada;
  assign conta_nave = v2_q & ret_nave2_q & dentro_inimiga;

  function automatic logic [CONT_W-1:0] inc_sat(input logic [CONT_W-1:0] c);
    return (&c) ? c : c + CONT_W'(1);
  endfunction

  estado_t             estado_q, estado_d;
  logic [CONT_W-1:0]   cont_ini_q, cont_ini_d;
  logic [CONT_W-1:0]   cont_nave_q, cont_nave_d;
  logic                hit_ini_q, hit_ini_d;
  logic                hit_nave_q, hit_nave_d;
  logic                valido_q, valido_d;
  logic                overrun_q, overrun_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      cont_ini_q  <= '0;
      cont_nave_q <= '0;
      hit_ini_q   <= 1'b0;
      hit_nave_q  <= 1'b0;
      valido_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cont_ini_q  <= cont_ini_d;
      cont_nave_q <= cont_nave_d;
      hit_ini_q   <= hit_ini_d;
      hit_nave_q  <= hit_nave_d;
      valido_q    <= valido_d;
      overrun_q   <= overrun_d;
    end
  end

  // Result handshake: valido rises after PUBLICA and stays until ack is seen high on an edge;
  // a result published while one is still pending (and not acked that cycle) raises overrun.
  always_comb begin
    estado_d    = estado_q;
    cont_ini_d  = cont_ini_q;
    cont_nave_d = cont_nave_q;
    hit_ini_d   = hit_ini_q;
    hit_nave_d  = hit_nave_q;
    valido_d    = valido_q;
    overrun_d   = overrun_q;

    if (ack && valido_q) begin
      valido_d  = 1'b0;
      overrun_d = 1'b0;
    end

    case (estado_q)
      OCIOSO: begin
        if (inicio && !pausa) begin
          estado_d    = ACUMULA;
          cont_ini_d  = '0;
          cont_nave_d = '0;
        end
      end
      ACUMULA: begin
        if (pausa) begin
          estado_d = OCIOSO;
        end else begin
          if (conta_ini)  cont_ini_d  = inc_sat(cont_ini_q);
          if (conta_nave) cont_nave_d = inc_sat(cont_nave_q);
          if (v2_q && ult2_q) estado_d = PUBLICA;
        end
      end
      PUBLICA: begin
        estado_d   = OCIOSO;
        hit_ini_d  = 32'(cont_ini_q) >= LIMIAR_U;
        hit_nave_d = 32'(cont_nave_q) >= LIMIAR_U;
        valido_d   = 1'b1;
        if (valido_q && !ack) overrun_d = 1'b1;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign hit_inimigo = hit_ini_q;
  assign hit_nave    = hit_nave_q;
  assign valido      = valido_q;
  assign overrun     = overrun_q;
  assign dbg_estado  = estado_q;

`ifdef COLISAO_DEBUG_EN
  logic [CONT_W-1:0] dbg_ini_q;
  logic [CONT_W-1:0] dbg_nave_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      dbg_ini_q  <= '0;
      dbg_nave_q <= '0;
    end else if (estado_q == PUBLICA) begin
      dbg_ini_q  <= cont_ini_q;
      dbg_nave_q <= cont_nave_q;
    end
  end

  assign dbg_cont_inimigo = dbg_ini_q;
  assign dbg_cont_nave    = dbg_nave_q;
`else
  assign dbg_cont_inimigo = '0;
  assign dbg_cont_nave    = '0;
`endif

endmodule
